// File: rtl/flags_seq_pkg.sv
// Shared definitions for the FLAGS save/restore sequencer and the flags register.
// FLAGS_PUSH_UPPER_ONES_EN: when defined, pushed images carry 4'hF in bits 15:12.
package flags_seq_pkg;

  typedef enum logic [1:0] {
    CMD_PUSHF     = 2'd0,
    CMD_POPF      = 2'd1,
    CMD_INT_ENTRY = 2'd2,
    CMD_RESERVED  = 2'd3
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PUSH,
    ST_CLEAR,
    ST_POP,
    ST_APPLY,
    ST_DONE
  } seq_state_e;

  // Bit positions inside the 16-bit FLAGS word.
  localparam int FLAG_CF = 0;
  localparam int FLAG_PF = 2;
  localparam int FLAG_AF = 4;
  localparam int FLAG_ZF = 6;
  localparam int FLAG_SF = 7;
  localparam int FLAG_TF = 8;
  localparam int FLAG_IF = 9;
  localparam int FLAG_DF = 10;
  localparam int FLAG_OF = 11;

  // Bit positions inside the 9-bit update_flags enable vector.
  localparam int UF_CF = 0;
  localparam int UF_PF = 1;
  localparam int UF_AF = 2;
  localparam int UF_ZF = 3;
  localparam int UF_SF = 4;
  localparam int UF_TF = 5;
  localparam int UF_IF = 6;
  localparam int UF_DF = 7;
  localparam int UF_OF = 8;

  localparam logic [8:0] UPDATE_TF_IF = (9'd1 << UF_TF) | (9'd1 << UF_IF);

  function automatic logic [15:0] push_image(input logic [15:0] flags);
`ifdef FLAGS_PUSH_UPPER_ONES_EN
    return {4'hF, flags[11:0]};
`else
    return flags;
`endif
  endfunction

endpackage

// File: rtl/flags_stack_sequencer_if.sv
// Single-word stack memory handshake between the flags sequencer and the bus unit.
interface flags_stack_sequencer_if;

  logic        mem_access;
  logic        mem_wr_en;
  logic [15:0] mem_addr;
  logic [15:0] mem_data_out;
  logic [15:0] mem_data_in;
  logic        mem_ack;

  modport master (
    output mem_access, mem_wr_en, mem_addr, mem_data_out,
    input  mem_data_in, mem_ack
  );

  modport slave (
    input  mem_access, mem_wr_en, mem_addr, mem_data_out,
    output mem_data_in, mem_ack
  );

endinterface

// File: rtl/flags_stack_sequencer.sv
// PUSHF / POPF / INT-entry engine moving the FLAGS word over the stack memory handshake.
// Optional FLAGS_PUSH_UPPER_ONES_EN (see flags_seq_pkg::push_image) sets pushed bits 15:12.
module flags_stack_sequencer
  import flags_seq_pkg::*;
#(
  parameter logic [15:0] STACK_STEP = 16'd2,
  parameter logic [8:0]  POP_MASK   = 9'h1FF
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            start,
  input  logic [1:0]                      cmd,
  input  logic [15:0]                     sp_in,
  input  logic [15:0]                     flags_cur,
  output logic                            busy,
  output logic                            done,
  output logic [15:0]                     sp_out,
  output logic                            sp_wr,
  output logic [15:0]                     flags_in,
  output logic [8:0]                      update_flags,
  flags_stack_sequencer_if.master         mem
);

  seq_state_e  state_q, state_d;
  cmd_e        cmd_q, cmd_d;
  logic [15:0] sp_q, sp_d;
  logic [15:0] data_q, data_d;
  logic [15:0] push_addr;

  assign push_addr = sp_q - STACK_STEP;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cmd_q   <= CMD_PUSHF;
      sp_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      sp_q    <= sp_d;
      data_q  <= data_d;
    end
  end

  // data_q holds the push snapshot taken at start, or the popped word after the ack.
  always_comb begin
    state_d          = state_q;
    cmd_d            = cmd_q;
    sp_d             = sp_q;
    data_d           = data_q;
    busy             = 1'b0;
    done             = 1'b0;
    sp_out           = '0;
    sp_wr            = 1'b0;
    flags_in         = '0;
    update_flags     = '0;
    mem.mem_access   = 1'b0;
    mem.mem_wr_en    = 1'b0;
    mem.mem_addr     = '0;
    mem.mem_data_out = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          cmd_d  = cmd_e'(cmd);
          sp_d   = sp_in;
          data_d = push_image(flags_cur);
          case (cmd_e'(cmd))
            CMD_PUSHF, CMD_INT_ENTRY: state_d = ST_PUSH;
            CMD_POPF:                 state_d = ST_POP;
            default:                  state_d = ST_DONE;
          endcase
        end
      end

      ST_PUSH: begin
        busy             = 1'b1;
        mem.mem_access   = 1'b1;
        mem.mem_wr_en    = 1'b1;
        mem.mem_addr     = push_addr;
        mem.mem_data_out = data_q;
        if (mem.mem_ack) begin
          sp_wr   = 1'b1;
          sp_out  = push_addr;
          state_d = (cmd_q == CMD_INT_ENTRY) ? ST_CLEAR : ST_DONE;
        end
      end

      ST_CLEAR: begin
        busy         = 1'b1;
        update_flags = UPDATE_TF_IF;
        state_d      = ST_DONE;
      end

      ST_POP: begin
        busy           = 1'b1;
        mem.mem_access = 1'b1;
        mem.mem_addr   = sp_q;
        if (mem.mem_ack) begin
          data_d  = mem.mem_data_in;
          state_d = ST_APPLY;
        end
      end

      ST_APPLY: begin
        busy         = 1'b1;
        update_flags = POP_MASK;
        flags_in     = (POP_MASK == '0) ? '0 : data_q;
        sp_wr        = 1'b1;
        sp_out       = sp_q + STACK_STEP;
        state_d      = ST_DONE;
      end

      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_flags_stack_sequencer.sv
// Directed self-checking bench for flags_stack_sequencer (honours FLAGS_PUSH_UPPER_ONES_EN).
module tb_flags_stack_sequencer;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [1:0]  cmd;
  logic [15:0] sp_in;
  logic [15:0] flags_cur;
  logic        busy;
  logic        done;
  logic [15:0] sp_out;
  logic        sp_wr;
  logic [15:0] flags_in;
  logic [8:0]  update_flags;

  int vectors     = 0;
  int miscompares = 0;
  int doneCount   = 0;

  flags_stack_sequencer_if memIf ();

  flags_stack_sequencer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .cmd          (cmd),
    .sp_in        (sp_in),
    .flags_cur    (flags_cur),
    .busy         (busy),
    .done         (done),
    .sp_out       (sp_out),
    .sp_wr        (sp_wr),
    .flags_in     (flags_in),
    .update_flags (update_flags),
    .mem          (memIf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // done is combinational from the state register, so mid-cycle sampling is stable.
  always @(negedge clk) if (done) doneCount++;

`ifdef FLAGS_PUSH_UPPER_ONES_EN
  localparam logic [15:0] PUSHF_IMAGE = 16'hFA95;
  localparam logic [15:0] INT_IMAGE   = 16'hF302;
`else
  localparam logic [15:0] PUSHF_IMAGE = 16'h0A95;
  localparam logic [15:0] INT_IMAGE   = 16'h0302;
`endif

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic startV, input logic [1:0] cmdV,
                               input logic [15:0] spV, input logic [15:0] flagsV,
                               input logic ackV, input logic [15:0] dataV);
    start             = startV;
    cmd               = cmdV;
    sp_in             = spV;
    flags_cur         = flagsV;
    memIf.mem_ack     = ackV;
    memIf.mem_data_in = dataV;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    applyStimulus(1'b0, 2'd0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_mem_access", memIf.mem_access, 0);
    checkOutput("reset_sp_wr", sp_wr, 0);
    checkOutput("reset_update_flags", update_flags, 0);
    checkOutput("reset_flags_in", flags_in, 0);
    checkOutput("reset_sp_out", sp_out, 0);
    step();
    step();
    reset_n = 1'b1;

    $display("[TB] PUSHF with delayed ack, stray start while busy");
    step();
    applyStimulus(1'b1, 2'd0, 16'h0100, 16'h0A95, 1'b0, 16'h0000);
    checkOutput("push_idle_busy", busy, 0);
    step();
    applyStimulus(1'b0, 2'd0, 16'h0100, 16'hFFFF, 1'b0, 16'h0000);
    checkOutput("push_busy", busy, 1);
    checkOutput("push_access", memIf.mem_access, 1);
    checkOutput("push_wr_en", memIf.mem_wr_en, 1);
    checkOutput("push_addr", memIf.mem_addr, 16'h00FE);
    checkOutput("push_data_snapshot", memIf.mem_data_out, PUSHF_IMAGE);
    checkOutput("push_wait_sp_wr", sp_wr, 0);
    step();
    applyStimulus(1'b1, 2'd1, 16'h5555, 16'h1234, 1'b0, 16'h0000);
    checkOutput("push_ignored_start_addr", memIf.mem_addr, 16'h00FE);
    checkOutput("push_ignored_start_access", memIf.mem_access, 1);
    step();
    applyStimulus(1'b0, 2'd0, 16'h0000, 16'h0000, 1'b1, 16'h0000);
    checkOutput("push_ack_sp_wr", sp_wr, 1);
    checkOutput("push_ack_sp_out", sp_out, 16'h00FE);
    checkOutput("push_ack_data", memIf.mem_data_out, PUSHF_IMAGE);
    checkOutput("push_ack_update_flags", update_flags, 0);
    step();
    applyStimulus(1'b0, 2'd0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
    checkOutput("push_done", done, 1);
    checkOutput("push_done_busy", busy, 0);
    checkOutput("push_done_access", memIf.mem_access, 0);
    checkOutput("push_done_sp_wr", sp_wr, 0);
    step();
    checkOutput("push_back_idle_done", done, 0);
    checkOutput("push_back_idle_busy", busy, 0);
    checkOutput("push_done_count", doneCount, 1);

    $display("[TB] INT_ENTRY with SP wrap and first-cycle ack");
    applyStimulus(1'b1, 2'd2, 16'h0000, 16'h0302, 1'b0, 16'h0000);
    step();
    applyStimulus(1'b0, 2'd0, 16'h0000, 16'h0302, 1'b1, 16'h0000);
    checkOutput("int_addr_wrap", memIf.mem_addr, 16'hFFFE);
    checkOutput("int_data", memIf.mem_data_out, INT_IMAGE);
    checkOutput("int_ack_sp_wr", sp_wr, 1);
    checkOutput("int_ack_sp_out", sp_out, 16'hFFFE);
    step();
    applyStimulus(1'b0, 2'd0, 16'h0000, 16'h0302, 1'b0, 16'h0000);
    checkOutput("int_clear_update", update_flags, 9'h060);
    checkOutput("int_clear_flags_in", flags_in, 16'h0000);
    checkOutput("int_clear_busy", busy, 1);
    checkOutput("int_clear_sp_wr", sp_wr, 0);
    checkOutput("int_clear_access", memIf.mem_access, 0);
    step();
    checkOutput("int_done", done, 1);
    checkOutput("int_done_update", update_flags, 0);
    step();
    checkOutput("int_done_count", doneCount, 2);

    $display("[TB] ack with no request is ignored");
    applyStimulus(1'b0, 2'd0, 16'h0000, 16'h0000, 1'b1, 16'hBEEF);
    checkOutput("stray_ack_sp_wr", sp_wr, 0);
    checkOutput("stray_ack_update", update_flags, 0);
    step();
    checkOutput("stray_ack_busy", busy, 0);
    checkOutput("stray_ack_done", done, 0);

    $display("[TB] POPF with first-cycle ack and SP wrap");
    applyStimulus(1'b1, 2'd1, 16'hFFFE, 16'h0000, 1'b0, 16'h0000);
    step();
    applyStimulus(1'b0, 2'd0, 16'h0000, 16'h0000, 1'b1, 16'h08D5);
    checkOutput("pop_access", memIf.mem_access, 1);
    checkOutput("pop_wr_en", memIf.mem_wr_en, 0);
    checkOutput("pop_addr", memIf.mem_addr, 16'hFFFE);
    checkOutput("pop_ack_sp_wr", sp_wr, 0);
    checkOutput("pop_ack_update", update_flags, 0);
    step();
    applyStimulus(1'b0, 2'd0, 16'h0000, 16'h0000, 1'b0, 16'h1111);
    checkOutput("pop_apply_flags_in", flags_in, 16'h08D5);
    checkOutput("pop_apply_update", update_flags, 9'h1FF);
    checkOutput("pop_apply_sp_wr", sp_wr, 1);
    checkOutput("pop_apply_sp_out", sp_out, 16'h0000);
    checkOutput("pop_apply_access", memIf.mem_access, 0);
    step();
    checkOutput("pop_done", done, 1);
    checkOutput("pop_done_flags_in", flags_in, 0);
    step();
    checkOutput("pop_done_count", doneCount, 3);

    $display("[TB] reserved command");
    applyStimulus(1'b1, 2'd3, 16'h0200, 16'h0001, 1'b0, 16'h0000);
    step();
    applyStimulus(1'b0, 2'd0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
    checkOutput("rsvd_done", done, 1);
    checkOutput("rsvd_access", memIf.mem_access, 0);
    checkOutput("rsvd_sp_wr", sp_wr, 0);
    step();
    checkOutput("rsvd_done_count", doneCount, 4);

    $display("[TB] reset mid-PUSH");
    applyStimulus(1'b1, 2'd0, 16'h0300, 16'h0001, 1'b0, 16'h0000);
    step();
    applyStimulus(1'b0, 2'd0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
    checkOutput("abort_pre_access", memIf.mem_access, 1);
    memIf.mem_ack = 1'b1;
    reset_n = 1'b0;
    #1;
    checkOutput("abort_access", memIf.mem_access, 0);
    checkOutput("abort_sp_wr", sp_wr, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_done", done, 0);
    step();
    memIf.mem_ack = 1'b0;
    reset_n = 1'b1;
    step();
    checkOutput("abort_idle_busy", busy, 0);
    checkOutput("abort_done_count", doneCount, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
